load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of data paths.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, width of address paths.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  execute stage presents a memory op.
REQ-006 SHALL have port req_ready  output  1  unit can accept a request (high only in IDLE).
REQ-007 SHALL have port is_store  input  1  1 = store, 0 = load.
REQ-008 SHALL have port funct3  input  3  RV32I size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-009 SHALL have port addr  input  ADDR_WIDTH  byte address.
REQ-010 SHALL have port store_data  input  DATA_WIDTH  store value, low-aligned.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port load_data  output  DATA_WIDTH  extended load result, valid with resp_valid.
REQ-013 SHALL have port resp_err  output  1  misaligned or illegal funct3, valid with resp_valid.
REQ-014 SHALL have port mem_wr_en  output  1  word write strobe to data memory.
REQ-015 SHALL have port mem_addr  output  ADDR_WIDTH  word-aligned memory address (bits [1:0] = 0).
REQ-016 SHALL have port mem_wr_data  output  DATA_WIDTH  full word to write.
REQ-017 SHALL have port mem_rd_data  input  DATA_WIDTH  memory word, valid the cycle after mem_addr is presented.

Function
REQ-018 SHALL accept a request when req_valid && req_ready at a rising edge, latching is_store, funct3, addr, store_data.
REQ-019 SHALL implement FSM states IDLE, READ, WRITE, RESP.
REQ-020 SHALL flag error on acceptance if funct3 in {011,110,111}, or halfword with addr[0]=1, or word with addr[1:0]!=0, or store with funct3 in {100,101}.
REQ-021 SHALL on error go IDLE->RESP with no memory access (mem_wr_en stays 0); resp_err=1, load_data=0.
REQ-022 SHALL for loads go IDLE->READ->RESP; resp_valid 2 cycles after acceptance.
REQ-023 SHALL for SW go IDLE->WRITE->RESP with mem_wr_en=1 in WRITE and mem_wr_data=store_data; resp_valid 2 cycles after acceptance.
REQ-024 SHALL for SB/SH perform read-modify-write IDLE->READ->WRITE->RESP; resp_valid 3 cycles after acceptance.
REQ-025 SHALL in READ drive mem_addr={addr[31:2],2'b00} and capture mem_rd_data into an internal word register on the exiting edge.
REQ-026 SHALL in WRITE replace only byte lane addr[1:0] (SB) or halfword lane addr[1] (SH) of the captured word, leaving other lanes unchanged.
REQ-027 SHALL select load byte/halfword by addr[1:0]/addr[1], sign-extend for LB/LH, zero-extend for LBU/LHU.
REQ-028 SHALL assert mem_wr_en only in WRITE, exactly one cycle per store.
REQ-029 SHALL hold mem_addr at the latched word address in READ/WRITE/RESP, 0 in IDLE.
REQ-030 SHALL assert resp_valid for exactly one cycle in RESP, then return to IDLE; req_ready=1 the following cycle (no back-to-back acceptance in RESP).
REQ-031 SHALL ignore req_valid while not in IDLE; inputs changing mid-operation have no effect.
REQ-032 SHALL hold load_data and resp_err at last response values until the next RESP.

Reset
REQ-033 SHALL on rst_n=0 immediately enter IDLE; req_ready=1, resp_valid=0, resp_err=0, load_data=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0.
REQ-034 SHALL abort any in-flight op on reset with no write issued after reset assertion; a write in progress is cut asynchronously.

Verification
REQ-035 SHALL pass: memory word 0x8899AABB at 0x02000004; LB addr 0x02000005 -> resp_valid at cycle 2, load_data=0xFFFFFFAA, resp_err=0.
REQ-036 SHALL pass: same word; LHU addr 0x02000006 -> load_data=0x00008899; LH -> 0xFFFF8899.
REQ-037 SHALL pass: word 0x11223344 at 0x02000008; SB data 0x000000EE to 0x0200000A -> one mem_wr_en pulse at cycle 2, mem_wr_data=0x11EE3344, resp_valid at cycle 3.
REQ-038 SHALL pass: SW 0xDEADBEEF to 0x0200000C -> mem_wr_en at cycle 1, mem_addr=0x0200000C, resp_valid at cycle 2, no READ state.
REQ-039 SHALL pass: LW addr 0x02000002 and funct3=011 -> resp_valid at cycle 1, resp_err=1, mem_wr_en never asserted.
REQ-040 SHALL pass: rst_n driven low during READ of an SH -> outputs at reset values within the same cycle, no mem_wr_en pulse, req_ready=1 after release.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: sizes, sign-extends and aligns byte/halfword/word accesses
// onto a word-wide data memory, using read-modify-write for sub-word stores.
module load_store_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  is_store,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] store_data,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  resp_err,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t                state;
    logic                  is_store_q;
    logic [2:0]            funct3_q;
    logic [1:0]            off_q;
    logic [DATA_WIDTH-1:0] store_data_q;

    logic                  req_err_c;
    logic [4:0]            shamt_c;
    logic [DATA_WIDTH-1:0] lane_c;
    logic [DATA_WIDTH-1:0] load_ext_c;
    logic [DATA_WIDTH-1:0] lane_mask_c;
    logic [DATA_WIDTH-1:0] merged_c;

    // Request legality: bad funct3, misalignment, or unsigned-size store
    always_comb begin
        req_err_c = 1'b0;
        case (funct3)
            3'b011, 3'b110, 3'b111: req_err_c = 1'b1;
            3'b001, 3'b101:         req_err_c = addr[0];
            3'b010:                 req_err_c = (addr[1:0] != 2'b00);
            default:                req_err_c = 1'b0;
        endcase
        if (is_store && funct3[2]) req_err_c = 1'b1;
    end

    // Lane extraction for loads and lane merge for sub-word stores
    always_comb begin
        shamt_c     = funct3_q[0] ? {off_q[1], 4'b0000} : {off_q, 3'b000};
        lane_c      = mem_rd_data >> shamt_c;
        lane_mask_c = funct3_q[0] ? DATA_WIDTH'(16'hFFFF) : DATA_WIDTH'(8'hFF);
        merged_c    = (mem_rd_data & ~(lane_mask_c << shamt_c)) |
                      ((store_data_q & lane_mask_c) << shamt_c);
        case (funct3_q)
            3'b000:  load_ext_c = {{(DATA_WIDTH-8){lane_c[7]}}, lane_c[7:0]};
            3'b001:  load_ext_c = {{(DATA_WIDTH-16){lane_c[15]}}, lane_c[15:0]};
            3'b100:  load_ext_c = {{(DATA_WIDTH-8){1'b0}}, lane_c[7:0]};
            3'b101:  load_ext_c = {{(DATA_WIDTH-16){1'b0}}, lane_c[15:0]};
            default: load_ext_c = lane_c;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            is_store_q   <= 1'b0;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            store_data_q <= '0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            load_data    <= '0;
            mem_wr_en    <= 1'b0;
            mem_addr     <= '0;
            mem_wr_data  <= '0;
        end else begin
            resp_valid <= 1'b0;
            mem_wr_en  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        is_store_q   <= is_store;
                        funct3_q     <= funct3;
                        off_q        <= addr[1:0];
                        store_data_q <= store_data;
                        req_ready    <= 1'b0;
                        mem_addr     <= {addr[ADDR_WIDTH-1:2], 2'b00};
                        if (req_err_c) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            load_data  <= '0;
                        end else if (is_store && funct3 == 3'b010) begin
                            state       <= WRITE;
                            mem_wr_en   <= 1'b1;
                            mem_wr_data <= store_data;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (is_store_q) begin
                        state       <= WRITE;
                        mem_wr_en   <= 1'b1;
                        mem_wr_data <= merged_c;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        load_data  <= load_ext_c;
                    end
                end
                WRITE: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    load_data  <= '0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    mem_addr  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        resp_valid;
    logic [31:0] load_data;
    logic        resp_err;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    logic [31:0] mem [0:15];
    int          total = 0;
    int          bad = 0;
    int          wr_total = 0;

    int          resp_cyc, resp_cnt, wr_cnt, wr_cyc;
    logic [31:0] wr_data, wr_addr, ld;
    logic        err;
    int          wr_before;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .is_store(is_store), .funct3(funct3), .addr(addr), .store_data(store_data),
        .resp_valid(resp_valid), .load_data(load_data), .resp_err(resp_err),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr[5:2]];

    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr[5:2]] <= mem_wr_data;
            wr_total <= wr_total + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request and record when responses/writes appear, counted from acceptance
    task automatic op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d);
        resp_cyc = 0; resp_cnt = 0; wr_cnt = 0; wr_cyc = 0;
        wr_data = '0; wr_addr = '0; ld = '0; err = 1'b0;
        req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = d;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(posedge clk);
            #1;
            if (resp_valid) begin
                resp_cnt++;
                if (resp_cyc == 0) begin
                    resp_cyc = k; ld = load_data; err = resp_err;
                end
            end
            if (mem_wr_en) begin
                wr_cnt++;
                if (wr_cyc == 0) begin
                    wr_cyc = k; wr_data = mem_wr_data; wr_addr = mem_addr;
                end
            end
            if (k == 1) begin
                req_valid = 1'b1; is_store = ~st; funct3 = 3'b010;
                addr = 32'h0200_0000; store_data = 32'h5A5A_5A5A;
            end else if (k == 2) begin
                req_valid = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = '0; store_data = '0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[1] = 32'h8899_AABB;
        mem[2] = 32'h1122_3344;
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wr_data", mem_wr_data, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        op(1'b0, 3'b000, 32'h0200_0005, 32'h0);
        chk("lb_resp_cyc", 32'(resp_cyc), 32'd2);
        chk("lb_resp_cnt", 32'(resp_cnt), 32'd1);
        chk("lb_data", ld, 32'hFFFF_FFAA);
        chk("lb_err", 32'(err), 32'd0);
        chk("lb_no_write", 32'(wr_cnt), 32'd0);
        chk("lb_hold_data", load_data, 32'hFFFF_FFAA);
        chk("lb_ready_after", 32'(req_ready), 32'd1);

        op(1'b0, 3'b101, 32'h0200_0006, 32'h0);
        chk("lhu_data", ld, 32'h0000_8899);
        op(1'b0, 3'b001, 32'h0200_0006, 32'h0);
        chk("lh_data", ld, 32'hFFFF_8899);
        op(1'b0, 3'b100, 32'h0200_0004, 32'h0);
        chk("lbu_data", ld, 32'h0000_00BB);
        op(1'b0, 3'b010, 32'h0200_0004, 32'h0);
        chk("lw_data", ld, 32'h8899_AABB);
        chk("lw_resp_cyc", 32'(resp_cyc), 32'd2);

        op(1'b1, 3'b000, 32'h0200_000A, 32'h0000_00EE);
        chk("sb_wr_cnt", 32'(wr_cnt), 32'd1);
        chk("sb_wr_cyc", 32'(wr_cyc), 32'd2);
        chk("sb_wr_data", wr_data, 32'h11EE_3344);
        chk("sb_wr_addr", wr_addr, 32'h0200_0008);
        chk("sb_resp_cyc", 32'(resp_cyc), 32'd3);
        chk("sb_err", 32'(err), 32'd0);
        op(1'b0, 3'b010, 32'h0200_0008, 32'h0);
        chk("sb_readback", ld, 32'h11EE_3344);

        op(1'b1, 3'b001, 32'h0200_000A, 32'h1234_CAFE);
        chk("sh_wr_data", wr_data, 32'hCAFE_3344);
        chk("sh_resp_cyc", 32'(resp_cyc), 32'd3);

        op(1'b1, 3'b010, 32'h0200_000C, 32'hDEAD_BEEF);
        chk("sw_wr_cyc", 32'(wr_cyc), 32'd1);
        chk("sw_wr_cnt", 32'(wr_cnt), 32'd1);
        chk("sw_wr_addr", wr_addr, 32'h0200_000C);
        chk("sw_wr_data", wr_data, 32'hDEAD_BEEF);
        chk("sw_resp_cyc", 32'(resp_cyc), 32'd2);
        chk("sw_mem", mem[3], 32'hDEAD_BEEF);

        op(1'b0, 3'b010, 32'h0200_0002, 32'h0);
        chk("lw_mis_resp_cyc", 32'(resp_cyc), 32'd1);
        chk("lw_mis_err", 32'(err), 32'd1);
        chk("lw_mis_data", ld, 32'h0);
        chk("lw_mis_no_write", 32'(wr_cnt), 32'd0);
        chk("err_hold", 32'(resp_err), 32'd1);
        op(1'b0, 3'b011, 32'h0200_0004, 32'h0);
        chk("f3_011_err", 32'(err), 32'd1);
        chk("f3_011_resp_cyc", 32'(resp_cyc), 32'd1);
        op(1'b1, 3'b100, 32'h0200_0004, 32'h77);
        chk("sbu_err", 32'(err), 32'd1);
        chk("sbu_no_write", 32'(wr_cnt), 32'd0);
        op(1'b0, 3'b001, 32'h0200_0005, 32'h0);
        chk("lh_odd_err", 32'(err), 32'd1);
        op(1'b0, 3'b000, 32'h0200_0007, 32'h0);
        chk("lb_ok_clears_err", 32'(err), 32'd0);
        chk("lb_top_byte", ld, 32'hFFFF_FF88);

        // Reset asserted while an SH is in its READ cycle
        wr_before = wr_total;
        req_valid = 1'b1; is_store = 1'b1; funct3 = 3'b001;
        addr = 32'h0200_0008; store_data = 32'h0000_5555;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_req_ready", 32'(req_ready), 32'd1);
        chk("arst_resp_valid", 32'(resp_valid), 32'd0);
        chk("arst_mem_wr_en", 32'(mem_wr_en), 32'd0);
        chk("arst_mem_addr", mem_addr, 32'h0);
        chk("arst_load_data", load_data, 32'h0);
        chk("arst_resp_err", 32'(resp_err), 32'd0);
        chk("arst_mem_wr_data", mem_wr_data, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("arst_no_write", 32'(wr_total - wr_before), 32'd0);
        chk("arst_mem_intact", mem[2], 32'hCAFE_3344);
        chk("arst_ready_after", 32'(req_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
